// File: rtl/tb_mem_arbiter.sv
// Two-port (instruction/data) round-robin arbiter in front of a shared SRAM model
// and a stdout character sink, with a fixed one-cycle response latency.
module tb_mem_arbiter #(
   parameter logic [31:0] SRAM_BASE   = 32'h1C00_0000,
   parameter logic [31:0] SRAM_LEN    = 32'h000F_C000,
   parameter logic [31:0] STDOUT_BASE = 32'h1A10_F000,
   parameter logic [31:0] STDOUT_LEN  = 32'h0000_1000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        data_req_i,
   input  logic [31:0] data_addr_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [17:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   output logic        stdout_valid_o,
   output logic [7:0]  stdout_char_o
);

   typedef enum logic [1:0] {KIND_MEM, KIND_STDOUT, KIND_ERR} kind_e;
   typedef enum logic {PORT_DATA = 1'b0, PORT_INSTR = 1'b1} port_e;

   // 33-bit compares keep the exclusive upper bound correct even if a window ends at 4 GiB.
   function automatic kind_e decode(input logic [31:0] addr);
      if ({1'b0, addr} >= {1'b0, SRAM_BASE} &&
          {1'b0, addr} <  {1'b0, SRAM_BASE} + {1'b0, SRAM_LEN})
         return KIND_MEM;
      if ({1'b0, addr} >= {1'b0, STDOUT_BASE} &&
          {1'b0, addr} <  {1'b0, STDOUT_BASE} + {1'b0, STDOUT_LEN})
         return KIND_STDOUT;
      return KIND_ERR;
   endfunction

   kind_e       instr_kind, data_kind;
   port_e       prio_q;
   logic        rsp_valid_q;
   port_e       rsp_owner_q;
   kind_e       rsp_kind_q;
   logic        rsp_we_q;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] instr_rdata_q, data_rdata_q;
   logic        instr_err_q, data_err_q;
   logic        stdout_hit;

   assign instr_kind = decode(instr_addr_i);
   assign data_kind  = decode(data_addr_i);
   assign stdout_hit = data_gnt_o && data_kind == KIND_STDOUT && data_we_i;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      instr_gnt_o = 1'b0;
      data_gnt_o  = 1'b0;
      if (!rst_i) begin
         if (data_req_i && (!instr_req_i || prio_q == PORT_DATA))
            data_gnt_o = 1'b1;
         else if (instr_req_i)
            instr_gnt_o = 1'b1;
      end
   end

   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_be_o    = '0;
      mem_wdata_o = '0;
      if (data_gnt_o && data_kind == KIND_MEM) begin
         mem_req_o   = 1'b1;
         mem_we_o    = data_we_i;
         mem_addr_o  = 18'((data_addr_i - SRAM_BASE) >> 2);
         mem_be_o    = data_be_i;
         mem_wdata_o = data_wdata_i;
      end else if (instr_gnt_o && instr_kind == KIND_MEM) begin
         mem_req_o  = 1'b1;
         mem_addr_o = 18'((instr_addr_i - SRAM_BASE) >> 2);
         mem_be_o   = 4'hF;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prio_q         <= PORT_DATA;
         rsp_valid_q    <= 1'b0;
         rsp_owner_q    <= PORT_DATA;
         rsp_kind_q     <= KIND_MEM;
         rsp_we_q       <= 1'b0;
         stdout_valid_o <= 1'b0;
         stdout_char_o  <= '0;
      end else begin
         rsp_valid_q    <= instr_gnt_o | data_gnt_o;
         stdout_valid_o <= stdout_hit;
         if (stdout_hit)
            stdout_char_o <= data_wdata_i[7:0];
         if (data_gnt_o) begin
            rsp_owner_q <= PORT_DATA;
            rsp_kind_q  <= data_kind;
            rsp_we_q    <= data_we_i;
            prio_q      <= PORT_INSTR;
         end else if (instr_gnt_o) begin
            rsp_owner_q <= PORT_INSTR;
            rsp_kind_q  <= instr_kind;
            rsp_we_q    <= 1'b0;
            prio_q      <= PORT_DATA;
         end
      end
   end

   // SRAM data arrives one cycle after the strobe, i.e. exactly in the response cycle.
   assign rsp_rdata = (rsp_kind_q == KIND_MEM && !rsp_we_q) ? mem_rdata_i : 32'h0;
   assign rsp_err   = (rsp_kind_q == KIND_ERR);

   assign instr_rvalid_o = rsp_valid_q && rsp_owner_q == PORT_INSTR;
   assign data_rvalid_o  = rsp_valid_q && rsp_owner_q == PORT_DATA;
   assign instr_rdata_o  = instr_rvalid_o ? rsp_rdata : instr_rdata_q;
   assign instr_err_o    = instr_rvalid_o ? rsp_err   : instr_err_q;
   assign data_rdata_o   = data_rvalid_o  ? rsp_rdata : data_rdata_q;
   assign data_err_o     = data_rvalid_o  ? rsp_err   : data_err_q;

   // Last delivered response per port, presented while that port has no rvalid.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         instr_rdata_q <= '0;
         instr_err_q   <= 1'b0;
         data_rdata_q  <= '0;
         data_err_q    <= 1'b0;
      end else begin
         if (instr_rvalid_o) begin
            instr_rdata_q <= rsp_rdata;
            instr_err_q   <= rsp_err;
         end
         if (data_rvalid_o) begin
            data_rdata_q <= rsp_rdata;
            data_err_q   <= rsp_err;
         end
      end
   end

endmodule

// File: tb/tb_tb_mem_arbiter.sv
// Randomized bench for tb_mem_arbiter: a transaction-level model predicts grants,
// SRAM strobes and responses every cycle; directed cases pin the model with literals.
module tb_tb_mem_arbiter;

   localparam logic [31:0] SB = 32'h1C00_0000;
   localparam logic [31:0] SL = 32'h000F_C000;
   localparam logic [31:0] OB = 32'h1A10_F000;
   localparam logic [31:0] OL = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_req = 1'b0;
   logic [31:0] instr_addr = '0;
   logic        instr_gnt, instr_rvalid, instr_err;
   logic [31:0] instr_rdata;
   logic        data_req = 1'b0;
   logic [31:0] data_addr = '0;
   logic        data_we = 1'b0;
   logic [3:0]  data_be = '0;
   logic [31:0] data_wdata = '0;
   logic        data_gnt, data_rvalid, data_err;
   logic [31:0] data_rdata;
   logic        mem_req, mem_we;
   logic [17:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        stdout_valid;
   logic [7:0]  stdout_char;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   tb_mem_arbiter #(
      .SRAM_BASE(SB), .SRAM_LEN(SL), .STDOUT_BASE(OB), .STDOUT_LEN(OL)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
      .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
      .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we),
      .data_be_i(data_be), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt),
      .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata), .data_err_o(data_err),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
      .stdout_valid_o(stdout_valid), .stdout_char_o(stdout_char)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // 0 = SRAM, 1 = stdout, 2 = error
   function automatic int kind_of(input logic [31:0] a);
      longint unsigned x, sb, ob;
      x  = a;
      sb = SB;
      ob = OB;
      if (x >= sb && x < sb + SL) return 0;
      if (x >= ob && x < ob + OL) return 1;
      return 2;
   endfunction

   typedef struct {
      bit          instr;
      int          kind;
      bit          we;
      logic [7:0]  ch;
   } rsp_t;

   rsp_t rsp_q[$];

   // Reference model and per-cycle comparison, evaluated mid-cycle after inputs settle.
   initial begin : compare
      bit          data_first;
      logic [31:0] hold_ir, hold_dr, rd, a, off;
      bit          hold_ie, hold_de;
      logic [7:0]  hold_ch;
      bit          e_iv, e_dv, e_sv, e_ig, e_dg, e_mreq, have;
      int          kind;
      rsp_t        r;
      data_first = 1; hold_ir = 0; hold_dr = 0; hold_ie = 0; hold_de = 0; hold_ch = 0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            check("rst_instr_gnt", instr_gnt, 0);
            check("rst_data_gnt", data_gnt, 0);
            check("rst_instr_rvalid", instr_rvalid, 0);
            check("rst_data_rvalid", data_rvalid, 0);
            check("rst_instr_err", instr_err, 0);
            check("rst_data_err", data_err, 0);
            check("rst_instr_rdata", instr_rdata, 0);
            check("rst_data_rdata", data_rdata, 0);
            check("rst_mem_req", mem_req, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_be", mem_be, 0);
            check("rst_mem_wdata", mem_wdata, 0);
            check("rst_stdout_valid", stdout_valid, 0);
            check("rst_stdout_char", stdout_char, 0);
            data_first = 1;
            rsp_q.delete();
            hold_ir = 0; hold_dr = 0; hold_ie = 0; hold_de = 0; hold_ch = 0;
         end else begin
            e_iv = 0; e_dv = 0; e_sv = 0;
            have = rsp_q.size() > 0;
            if (have) begin
               r  = rsp_q.pop_front();
               rd = (r.kind == 0 && !r.we) ? mem_rdata : 32'h0;
               if (r.instr) begin
                  e_iv = 1; hold_ir = rd; hold_ie = (r.kind == 2);
               end else begin
                  e_dv = 1; hold_dr = rd; hold_de = (r.kind == 2);
                  if (r.kind == 1 && r.we) begin
                     e_sv = 1; hold_ch = r.ch;
                  end
               end
            end
            check("instr_rvalid", instr_rvalid, e_iv);
            check("data_rvalid", data_rvalid, e_dv);
            check("instr_rdata", instr_rdata, hold_ir);
            check("instr_err", instr_err, hold_ie);
            check("data_rdata", data_rdata, hold_dr);
            check("data_err", data_err, hold_de);
            check("stdout_valid", stdout_valid, e_sv);
            check("stdout_char", stdout_char, hold_ch);

            e_dg   = data_req && (!instr_req || data_first);
            e_ig   = instr_req && !e_dg;
            kind   = e_dg ? kind_of(data_addr) : kind_of(instr_addr);
            e_mreq = (e_dg || e_ig) && kind == 0;
            check("instr_gnt", instr_gnt, e_ig);
            check("data_gnt", data_gnt, e_dg);
            check("mem_req", mem_req, e_mreq);
            if (e_mreq) begin
               a   = e_dg ? data_addr : instr_addr;
               off = a - SB;
               check("mem_addr", mem_addr, 32'(off[19:2]));
               check("mem_we", mem_we, e_dg ? data_we : 1'b0);
               check("mem_be", mem_be, e_dg ? data_be : 4'hF);
               if (e_dg && data_we) check("mem_wdata", mem_wdata, data_wdata);
            end
            if (e_dg) begin
               r.instr = 0; r.kind = kind; r.we = data_we; r.ch = data_wdata[7:0];
               rsp_q.push_back(r);
               data_first = 0;
            end else if (e_ig) begin
               r.instr = 1; r.kind = kind; r.we = 0; r.ch = 0;
               rsp_q.push_back(r);
               data_first = 1;
            end
         end
      end
   end

   task automatic drive(input bit ir, input logic [31:0] ia, input bit dr, input logic [31:0] da,
                        input bit we, input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] mr);
      @(negedge clk);
      rst = 0;
      instr_req = ir; instr_addr = ia;
      data_req = dr; data_addr = da; data_we = we; data_be = be; data_wdata = wd;
      mem_rdata = mr;
   endtask

   task automatic idle(input logic [31:0] mr);
      drive(0, 32'h0, 0, 32'h0, 0, 4'h0, 32'h0, mr);
   endtask

   // Requests stay asserted during reset to show that grants and strobes are suppressed.
   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1;
      instr_req = 1; instr_addr = SB;
      data_req = 1; data_addr = SB + 4; data_we = 1; data_be = 4'hF; data_wdata = $urandom();
      mem_rdata = $urandom();
      repeat (n - 1) @(negedge clk);
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 10))
         0:       return SB;
         1:       return SB + SL - 4;
         2:       return SB + SL;
         3:       return SB - 1;
         4:       return OB + $urandom_range(0, OL - 1);
         5:       return OB + OL;
         6:       return OB - 1;
         7:       return OB + OL - 1;
         8:       return $urandom();
         default: return SB + $urandom_range(0, SL - 1);
      endcase
   endfunction

   initial begin : stimulus
      do_reset(3);

      // Data read from SRAM, data returned one cycle later.
      drive(0, 32'h0, 1, 32'h1C00_0010, 0, 4'hF, 32'h0, $urandom());
      #3;
      check("r020_gnt", data_gnt, 1);
      check("r020_mem_addr", mem_addr, 32'h4);
      idle(32'hCAFE_0001);
      #3;
      check("r020_rvalid", data_rvalid, 1);
      check("r020_rdata", data_rdata, 32'hCAFE_0001);
      check("r020_err", data_err, 0);

      // Both ports contend after reset: D, I, D, I.
      do_reset(2);
      for (int i = 0; i < 4; i++) begin
         drive(1, SB + 32'(4 * i), 1, SB + 32'h100 + 32'(4 * i), 0, 4'hF, 32'h0, $urandom());
         #3;
         check("r021_data_gnt", data_gnt, (i % 2) == 0);
         check("r021_instr_gnt", instr_gnt, (i % 2) == 1);
         check("r021_data_rvalid", data_rvalid, i > 0 && ((i - 1) % 2) == 0);
         check("r021_instr_rvalid", instr_rvalid, i > 0 && ((i - 1) % 2) == 1);
      end
      idle($urandom());
      #3;
      check("r021_last_rvalid", instr_rvalid, 1);

      // Character write to stdout.
      drive(0, 32'h0, 1, 32'h1A10_F000, 1, 4'hF, 32'h0000_0041, $urandom());
      #3;
      check("r022_mem_req", mem_req, 0);
      idle($urandom());
      #3;
      check("r022_stdout_valid", stdout_valid, 1);
      check("r022_stdout_char", stdout_char, 32'h41);
      check("r022_rvalid", data_rvalid, 1);
      check("r022_err", data_err, 0);
      idle($urandom());
      #3;
      check("r022_strobe_len", stdout_valid, 0);
      check("r022_char_hold", stdout_char, 32'h41);

      // Fetches outside every window.
      drive(1, 32'h1C0F_C000, 0, 32'h0, 0, 4'h0, 32'h0, $urandom());
      #3;
      check("r023_past_sram_mem_req", mem_req, 0);
      drive(1, 32'h0000_0000, 0, 32'h0, 0, 4'h0, 32'h0, $urandom());
      #3;
      check("r023_zero_mem_req", mem_req, 0);
      check("r023_a_err", instr_err, 1);
      check("r023_a_rdata", instr_rdata, 0);
      idle($urandom());
      #3;
      check("r023_b_rvalid", instr_rvalid, 1);
      check("r023_b_err", instr_err, 1);

      // Last SRAM word.
      drive(1, 32'h1C0F_BFFC, 0, 32'h0, 0, 4'h0, 32'h0, $urandom());
      #3;
      check("r024_mem_req", mem_req, 1);
      check("r024_mem_addr", mem_addr, 32'h3_EFFF);
      idle(32'h1234_5678);
      #3;
      check("r024_rdata", instr_rdata, 32'h1234_5678);

      // Reset while a data response is in flight.
      drive(0, 32'h0, 1, SB + 32'h8, 0, 4'hF, 32'h0, $urandom());
      #3;
      check("r025_gnt", data_gnt, 1);
      do_reset(2);
      #3;
      check("r025_rvalid_in_rst", data_rvalid, 0);
      drive(1, SB, 1, SB + 32'h4, 0, 4'hF, 32'h0, $urandom());
      #3;
      check("r025_post_data_gnt", data_gnt, 1);
      check("r025_post_instr_gnt", instr_gnt, 0);
      check("r025_no_stale_rvalid", data_rvalid, 0);

      // Random traffic with occasional resets.
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 99) == 0)
            do_reset(1 + $urandom_range(0, 1));
         else
            drive($urandom_range(0, 3) != 0, rand_addr(),
                  $urandom_range(0, 3) != 0, rand_addr(), 1'($urandom()),
                  4'($urandom()), $urandom(), $urandom());
      end
      idle($urandom());
      idle($urandom());
      @(negedge clk);
      #4;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/tb_mem_arbiter.md
TB_MEM_ARBITER -- requirements
Module: tb_mem_arbiter

Interface
REQ-001 SHALL have parameter SRAM_BASE, default 32'h1C00_0000, base byte address of the shared SRAM model.
REQ-002 SHALL have parameter SRAM_LEN, default 32'h000F_C000, SRAM window length in bytes.
REQ-003 SHALL have parameter STDOUT_BASE, default 32'h1A10_F000, base of the stdout character sink.
REQ-004 SHALL have parameter STDOUT_LEN, default 32'h0000_1000, stdout window length in bytes.
REQ-005 SHALL have ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- instr_req_i  in  1  instruction fetch request.
- instr_addr_i  in  32  fetch byte address.
- instr_gnt_o  out  1  fetch request accepted this cycle.
- instr_rvalid_o  out  1  fetch response valid.
- instr_rdata_o  out  32  fetch response data.
- instr_err_o  out  1  fetch response error (qualified by rvalid).
- data_req_i  in  1  data request.
- data_addr_i  in  32  data byte address.
- data_we_i  in  1  1 = write.
- data_be_i  in  4  byte enables.
- data_wdata_i  in  32  write data.
- data_gnt_o  out  1  data request accepted this cycle.
- data_rvalid_o  out  1  data response valid.
- data_rdata_o  out  32  data response read data.
- data_err_o  out  1  data response error (qualified by rvalid).
- mem_req_o  out  1  SRAM access strobe.
- mem_we_o  out  1  SRAM write.
- mem_addr_o  out  18  SRAM word address, (addr - SRAM_BASE)[19:2].
- mem_be_o  out  4  SRAM byte enables.
- mem_wdata_o  out  32  SRAM write data.
- mem_rdata_i  in  32  SRAM read data, valid one cycle after mem_req_o.
- stdout_valid_o  out  1  one-cycle character strobe.
- stdout_char_o  out  8  character, data_wdata_i[7:0] of the accepted write.

Function
REQ-006 SHALL decode each request as MEM (SRAM_BASE <= addr < SRAM_BASE+SRAM_LEN), STDOUT (STDOUT_BASE <= addr < STDOUT_BASE+STDOUT_LEN) or ERR (all other addresses); comparisons unsigned 32-bit, upper bound exclusive.
REQ-007 SHALL grant at most one requester per cycle; gnt is combinational from req and arbiter state, asserted in the same cycle as req.
REQ-008 SHALL arbitrate round-robin with a 1-bit priority register: on a simultaneous request the prioritised port is granted; after any grant, priority moves to the non-granted port.
REQ-009 SHALL grant a lone requester regardless of priority.
REQ-010 SHALL, for a granted MEM request, drive mem_req_o=1 and mem_we_o/mem_addr_o/mem_be_o/mem_wdata_o in the grant cycle; the instruction port always drives mem_we_o=0 and mem_be_o=4'hF.
REQ-011 SHALL keep mem_req_o=0 for STDOUT and ERR requests.
REQ-012 SHALL register the response (owner, kind) at the grant edge and assert exactly one rvalid, on the owner port, in the cycle after the grant: fixed latency 1.
REQ-013 SHALL return mem_rdata_i on a MEM read response, rdata 32'h0 on every STDOUT, ERR and write response, err=1 only for ERR.
REQ-014 SHALL, on a granted STDOUT write, pulse stdout_valid_o for exactly one cycle, concurrent with data_rvalid_o, with stdout_char_o registered from data_wdata_i[7:0]; a STDOUT read produces no strobe.
REQ-015 SHALL sustain back-to-back grants (one per cycle); a grant and the previous grant's rvalid coexist in one cycle.
REQ-016 SHALL hold rdata/err of the non-owner port, and stdout_char_o when idle, at their last value; only rvalid and stdout_valid_o qualify them.

Reset
REQ-017 SHALL, while rst_i=1, force all gnt, rvalid, err, mem_req_o, mem_we_o and stdout_valid_o to 0, all data/address outputs to 0, and priority to the data port.
REQ-018 SHALL discard a response in flight when rst_i asserts; no rvalid or stdout strobe is emitted for it after release.
REQ-019 SHALL accept requests in the first clock edge after rst_i deasserts.

Verification
REQ-020 Data read of 0x1C00_0010 with mem_rdata_i=32'hCAFE_0001 -> gnt same cycle, mem_addr_o=18'h4, data_rvalid_o next cycle with rdata 32'hCAFE_0001, err 0.
REQ-021 Both ports request MEM every cycle for 4 cycles after reset -> grants D, I, D, I; each rvalid one cycle after its grant on the matching port.
REQ-022 Data write 0x1A10_F000, wdata 32'h0000_0041 -> no mem_req_o; next cycle stdout_valid_o=1, stdout_char_o=8'h41, data_rvalid_o=1, err 0.
REQ-023 Fetch from 0x1C0F_C000 (first byte past SRAM) and 0x0000_0000 -> no mem_req_o; instr_rvalid_o with err 1, rdata 0.
REQ-024 Boundary: fetch 0x1C0F_BFFC -> MEM, mem_addr_o=18'h3EFFF.
REQ-025 Assert rst_i in the cycle after a data grant -> rvalid stays 0 through and after reset; first post-reset simultaneous request goes to data.
